// File: rtl/mmu_pkg.sv
// Shared definitions for the memory-access side of the MMU: exception codes,
// MAT and access-size encodings, and the request-stage state type.
package mmu_pkg;

  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_TLBR = 6'h3F;
  localparam logic [5:0] ECODE_PIL  = 6'h01;
  localparam logic [5:0] ECODE_PIS  = 6'h02;
  localparam logic [5:0] ECODE_PPI  = 6'h07;
  localparam logic [5:0] ECODE_PME  = 6'h04;

  localparam logic [1:0] MAT_SUC = 2'd0;
  localparam logic [1:0] MAT_CC  = 2'd1;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } stage_state_e;

  // Natural alignment: halves on even bytes, words on 4-byte boundaries.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    return ((size == SIZE_H) && lo[0]) || ((size == SIZE_W) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_req_stage_if.sv
// Upstream request/response bundle and data-cache request bundle.
interface mem_req_stage_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic              in_is_store;
  logic [1:0]        in_size;
  logic [DATA_W-1:0] in_wdata;
  logic [3:0]        in_wstrb;
  logic [ADDR_W-1:0] in_vaddr;
  logic [ADDR_W-1:0] in_paddr;
  logic              in_is_dmw;
  logic              in_is_usetlb;
  logic [1:0]        in_mat;
  logic [1:0]        in_plv;
  logic              tlb_found;
  logic              tlb_v;
  logic              tlb_d;
  logic [1:0]        tlb_plv;
  logic              out_valid;
  logic [DATA_W-1:0] out_rdata;
  logic              out_exc;
  logic [5:0]        out_ecode;
  logic [ADDR_W-1:0] out_badv;

  modport master (
    output in_valid, in_is_store, in_size, in_wdata, in_wstrb, in_vaddr, in_paddr,
           in_is_dmw, in_is_usetlb, in_mat, in_plv, tlb_found, tlb_v, tlb_d, tlb_plv,
    input  in_ready, out_valid, out_rdata, out_exc, out_ecode, out_badv
  );

  modport slave (
    input  in_valid, in_is_store, in_size, in_wdata, in_wstrb, in_vaddr, in_paddr,
           in_is_dmw, in_is_usetlb, in_mat, in_plv, tlb_found, tlb_v, tlb_d, tlb_plv,
    output in_ready, out_valid, out_rdata, out_exc, out_ecode, out_badv
  );
endinterface

interface mem_dc_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              dc_req;
  logic              dc_wr;
  logic              dc_uncached;
  logic [1:0]        dc_size;
  logic [ADDR_W-1:0] dc_addr;
  logic [DATA_W-1:0] dc_wdata;
  logic [3:0]        dc_wstrb;
  logic              dc_addr_ok;
  logic              dc_data_ok;
  logic [DATA_W-1:0] dc_rdata;

  modport master (
    output dc_req, dc_wr, dc_uncached, dc_size, dc_addr, dc_wdata, dc_wstrb,
    input  dc_addr_ok, dc_data_ok, dc_rdata
  );

  modport slave (
    input  dc_req, dc_wr, dc_uncached, dc_size, dc_addr, dc_wdata, dc_wstrb,
    output dc_addr_ok, dc_data_ok, dc_rdata
  );
endinterface

// File: rtl/mem_perm_check.sv
// Alignment and TLB permission check for one data access; first match wins.
module mem_perm_check
  import mmu_pkg::*;
(
  input  logic       is_store,
  input  logic [1:0] size,
  input  logic [1:0] vaddr_lo,
  input  logic       use_tlb,
  input  logic       tlb_found,
  input  logic       tlb_v,
  input  logic       tlb_d,
  input  logic [1:0] plv,
  input  logic [1:0] tlb_plv,
  output logic       exc,
  output logic [5:0] ecode
);

  // Priority chain: ALE, then TLB checks only when the TLB did the translation.
  always_comb begin
    exc   = 1'b0;
    ecode = '0;
    if (is_misaligned(size, vaddr_lo)) begin
      exc   = 1'b1;
      ecode = ECODE_ALE;
    end else if (use_tlb) begin
      if (!tlb_found) begin
        exc   = 1'b1;
        ecode = ECODE_TLBR;
      end else if (!tlb_v) begin
        exc   = 1'b1;
        ecode = is_store ? ECODE_PIS : ECODE_PIL;
      end else if (plv > tlb_plv) begin
        exc   = 1'b1;
        ecode = ECODE_PPI;
      end else if (is_store && !tlb_d) begin
        exc   = 1'b1;
        ecode = ECODE_PME;
      end
    end
  end

endmodule

// File: rtl/mem_req_stage.sv
// Memory-request stage: latches one translated load/store, checks it, then
// either reports an exception or runs one addr_ok/data_ok cache transaction.
module mem_req_stage
  import mmu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  mem_req_stage_if.slave  up,
  mem_dc_if.master        dc
);

  stage_state_e      state_q, state_d;
  logic              is_store_q, is_dmw_q, usetlb_q, found_q, v_q, d_q;
  logic [1:0]        size_q, mat_q, plv_q, tplv_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wstrb_q;
  logic [ADDR_W-1:0] vaddr_q, paddr_q;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              capture;
  logic              exc;
  logic [5:0]        ecode;
  logic              req_active;
  logic              exc_rsp;

  mem_perm_check u_perm (
    .is_store  (is_store_q),
    .size      (size_q),
    .vaddr_lo  (vaddr_q[1:0]),
    .use_tlb   (usetlb_q & ~is_dmw_q),
    .tlb_found (found_q),
    .tlb_v     (v_q),
    .tlb_d     (d_q),
    .plv       (plv_q),
    .tlb_plv   (tplv_q),
    .exc       (exc),
    .ecode     (ecode)
  );

  // The first REQ cycle doubles as the check cycle: a faulting request never
  // raises dc_req and answers with its exception in that same cycle.
  assign req_active = (state_q == ST_REQ) && !exc;
  assign exc_rsp    = (state_q == ST_REQ) && exc;

  // Next-state and completion logic.
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    capture     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (up.in_valid && !flush) begin
          capture = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (exc) begin
          state_d = ST_IDLE;
        end else if (dc.dc_addr_ok) begin
          if (dc.dc_data_ok) begin
            state_d = ST_IDLE;
            if (!flush) begin
              rsp_valid_d = 1'b1;
              rsp_rdata_d = is_store_q ? '0 : dc.dc_rdata;
            end
          end else begin
            state_d = flush ? ST_DRAIN : ST_WAIT;
          end
        end else if (flush) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (dc.dc_data_ok) begin
          state_d = ST_IDLE;
          if (!flush) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = is_store_q ? '0 : dc.dc_rdata;
          end
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (dc.dc_data_ok) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, response and latched-request registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      is_store_q  <= 1'b0;
      size_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      vaddr_q     <= '0;
      paddr_q     <= '0;
      is_dmw_q    <= 1'b0;
      usetlb_q    <= 1'b0;
      mat_q       <= '0;
      plv_q       <= '0;
      found_q     <= 1'b0;
      v_q         <= 1'b0;
      d_q         <= 1'b0;
      tplv_q      <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      if (capture) begin
        is_store_q <= up.in_is_store;
        size_q     <= up.in_size;
        wdata_q    <= up.in_wdata;
        wstrb_q    <= up.in_wstrb;
        vaddr_q    <= up.in_vaddr;
        paddr_q    <= up.in_paddr;
        is_dmw_q   <= up.in_is_dmw;
        usetlb_q   <= up.in_is_usetlb;
        mat_q      <= up.in_mat;
        plv_q      <= up.in_plv;
        found_q    <= up.tlb_found;
        v_q        <= up.tlb_v;
        d_q        <= up.tlb_d;
        tplv_q     <= up.tlb_plv;
      end
    end
  end

  assign up.in_ready  = (state_q == ST_IDLE);
  assign up.out_valid = rsp_valid_q | exc_rsp;
  assign up.out_rdata = rsp_rdata_q;
  assign up.out_exc   = exc_rsp;
  assign up.out_ecode = exc_rsp ? ecode : '0;
  assign up.out_badv  = exc_rsp ? vaddr_q : '0;

  assign dc.dc_req      = req_active;
  assign dc.dc_wr       = req_active & is_store_q;
  assign dc.dc_uncached = req_active & (mat_q == MAT_SUC);
  assign dc.dc_size     = req_active ? size_q  : '0;
  assign dc.dc_addr     = req_active ? paddr_q : '0;
  assign dc.dc_wdata    = req_active ? wdata_q : '0;
  assign dc.dc_wstrb    = req_active ? wstrb_q : '0;

endmodule

// File: tb/tb_mem_req_stage.sv
// Directed bench for mem_req_stage: a vector table for the check/response
// paths plus hand sequences for stalls, flushes and reset mid-transaction.
module tb_mem_req_stage;
  import mmu_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_req_stage_if #(.ADDR_W(32), .DATA_W(32)) up ();
  mem_dc_if        #(.ADDR_W(32), .DATA_W(32)) dc ();

  mem_req_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .up     (up.slave),
    .dc     (dc.master)
  );

  typedef struct {
    logic        st;
    logic [1:0]  size;
    logic [31:0] vaddr;
    logic [31:0] paddr;
    logic        dmw;
    logic        utlb;
    logic [1:0]  mat;
    logic [1:0]  plv;
    logic        found;
    logic        v;
    logic        d;
    logic [1:0]  tplv;
    logic [31:0] rdata;
    logic        exc;
    logic [5:0]  ecode;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic st, input logic [1:0] size, input logic [31:0] vaddr,
                              input logic [31:0] paddr, input logic dmw, input logic utlb,
                              input logic [1:0] mat, input logic [1:0] plv, input logic found,
                              input logic v, input logic d, input logic [1:0] tplv,
                              input logic [31:0] rdata, input logic exc, input logic [5:0] ecode);
    vec_t r;
    r.st = st; r.size = size; r.vaddr = vaddr; r.paddr = paddr; r.dmw = dmw; r.utlb = utlb;
    r.mat = mat; r.plv = plv; r.found = found; r.v = v; r.d = d; r.tplv = tplv;
    r.rdata = rdata; r.exc = exc; r.ecode = ecode;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input vec_t x, input logic [31:0] wdata);
    up.in_is_store  = x.st;
    up.in_size      = x.size;
    up.in_wdata     = wdata;
    up.in_wstrb     = 4'b1010;
    up.in_vaddr     = x.vaddr;
    up.in_paddr     = x.paddr;
    up.in_is_dmw    = x.dmw;
    up.in_is_usetlb = x.utlb;
    up.in_mat       = x.mat;
    up.in_plv       = x.plv;
    up.tlb_found    = x.found;
    up.tlb_v        = x.v;
    up.tlb_d        = x.d;
    up.tlb_plv      = x.tplv;
  endtask

  // Present a request in IDLE and let it be captured on the next edge.
  task automatic capture(input vec_t x, input logic [31:0] wdata);
    drive_req(x, wdata);
    up.in_valid = 1'b1;
    step();
    up.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    vec_t x;
    logic [31:0] exp_rd;
    up.in_valid = 1'b0;
    drive_req(mk(0, SIZE_B, 0, 0, 0, 0, MAT_SUC, 0, 0, 0, 0, 0, 0, 0, 0), 32'h0);
    dc.dc_addr_ok = 1'b0;
    dc.dc_data_ok = 1'b0;
    dc.dc_rdata   = 32'h0;

    // Reset state
    #2 resetn = 1'b0;
    #2;
    chk("rst.in_ready",    up.in_ready, 1);
    chk("rst.out_valid",   up.out_valid, 0);
    chk("rst.out_exc",     up.out_exc, 0);
    chk("rst.dc_req",      dc.dc_req, 0);
    chk("rst.dc_uncached", dc.dc_uncached, 0);
    chk("rst.dc_addr",     dc.dc_addr, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    step();

    //         st size    vaddr         paddr         dmw utlb mat      plv fnd v d tplv rdata         exc ecode
    vecs[0]  = mk(0, SIZE_W, 32'h8000_1000, 32'h0000_1000, 1, 0, MAT_CC,  0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0, 6'h00);
    vecs[1]  = mk(1, SIZE_H, 32'h8000_0003, 32'h0000_0003, 1, 0, MAT_CC,  0, 0, 0, 0, 0, 32'h0,         1, 6'h09);
    vecs[2]  = mk(1, SIZE_W, 32'h0040_0000, 32'h0120_0000, 0, 1, MAT_CC,  0, 1, 1, 0, 0, 32'h0,         1, 6'h04);
    vecs[3]  = mk(1, SIZE_W, 32'h0040_0004, 32'h0120_0004, 0, 1, MAT_CC,  0, 0, 1, 0, 0, 32'h0,         1, 6'h3F);
    vecs[4]  = mk(0, SIZE_W, 32'h0040_0008, 32'h0120_0008, 0, 1, MAT_CC,  0, 1, 0, 1, 0, 32'h0,         1, 6'h01);
    vecs[5]  = mk(1, SIZE_W, 32'h0040_000C, 32'h0120_000C, 0, 1, MAT_CC,  0, 1, 0, 1, 0, 32'h0,         1, 6'h02);
    vecs[6]  = mk(0, SIZE_W, 32'h0040_0010, 32'h0120_0010, 0, 1, MAT_CC,  3, 1, 1, 1, 0, 32'h0,         1, 6'h07);
    vecs[7]  = mk(0, SIZE_W, 32'h8000_0002, 32'h0000_0002, 1, 0, MAT_CC,  0, 0, 0, 0, 0, 32'h0,         1, 6'h09);
    vecs[8]  = mk(1, SIZE_W, 32'h0040_0020, 32'h0120_0020, 0, 1, MAT_CC,  0, 1, 1, 1, 3, 32'h0,         0, 6'h00);
    vecs[9]  = mk(0, SIZE_W, 32'h9000_0040, 32'h1000_0040, 1, 0, MAT_SUC, 3, 0, 0, 0, 0, 32'h0BAD_F00D, 0, 6'h00);
    vecs[10] = mk(0, SIZE_B, 32'h0000_1003, 32'h0000_1003, 0, 0, MAT_CC,  0, 0, 0, 0, 0, 32'h0000_0077, 0, 6'h00);
    vecs[11] = mk(0, SIZE_H, 32'h0040_0001, 32'h0120_0001, 0, 1, MAT_CC,  0, 0, 0, 0, 0, 32'h0,         1, 6'h09);

    for (int i = 0; i < 12; i++) begin
      x = vecs[i];
      capture(x, 32'hCAFE_0000 | i);
      if (x.exc) begin
        chk($sformatf("v%0d.out_valid", i), up.out_valid, 1);
        chk($sformatf("v%0d.out_exc", i),   up.out_exc, 1);
        chk($sformatf("v%0d.ecode", i),     up.out_ecode, x.ecode);
        chk($sformatf("v%0d.badv", i),      up.out_badv, x.vaddr);
        chk($sformatf("v%0d.dc_req", i),    dc.dc_req, 0);
        chk($sformatf("v%0d.in_ready", i),  up.in_ready, 0);
        step();
        chk($sformatf("v%0d.pulse", i),     up.out_valid, 0);
        chk($sformatf("v%0d.idle", i),      up.in_ready, 1);
        chk($sformatf("v%0d.no_req", i),    dc.dc_req, 0);
      end else begin
        exp_rd = x.st ? 32'h0 : x.rdata;
        chk($sformatf("v%0d.dc_req", i),      dc.dc_req, 1);
        chk($sformatf("v%0d.dc_wr", i),       dc.dc_wr, x.st);
        chk($sformatf("v%0d.dc_uncached", i), dc.dc_uncached, (x.mat == MAT_SUC));
        chk($sformatf("v%0d.dc_addr", i),     dc.dc_addr, x.paddr);
        chk($sformatf("v%0d.dc_size", i),     dc.dc_size, x.size);
        chk($sformatf("v%0d.dc_wdata", i),    dc.dc_wdata, 32'hCAFE_0000 | i);
        chk($sformatf("v%0d.dc_wstrb", i),    dc.dc_wstrb, 4'b1010);
        chk($sformatf("v%0d.early", i),       up.out_valid, 0);
        dc.dc_addr_ok = 1'b1;
        step();
        dc.dc_addr_ok = 1'b0;
        chk($sformatf("v%0d.wait_req", i),    dc.dc_req, 0);
        chk($sformatf("v%0d.wait_valid", i),  up.out_valid, 0);
        dc.dc_data_ok = 1'b1;
        dc.dc_rdata   = x.st ? 32'hFFFF_FFFF : x.rdata;
        step();
        dc.dc_data_ok = 1'b0;
        chk($sformatf("v%0d.out_valid", i),   up.out_valid, 1);
        chk($sformatf("v%0d.out_exc", i),     up.out_exc, 0);
        chk($sformatf("v%0d.out_rdata", i),   up.out_rdata, exp_rd);
        chk($sformatf("v%0d.in_ready", i),    up.in_ready, 1);
        step();
        chk($sformatf("v%0d.pulse", i),       up.out_valid, 0);
      end
    end

    // Uncached load with addr_ok withheld 5 cycles, then addr_ok+data_ok together
    x = mk(0, SIZE_W, 32'hA000_0010, 32'h0000_0010, 1, 0, MAT_SUC, 0, 0, 0, 0, 0, 32'h1234_5678, 0, 6'h00);
    capture(x, 32'h0);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d.dc_req", k),   dc.dc_req, 1);
      chk($sformatf("stall%0d.dc_addr", k),  dc.dc_addr, 32'h0000_0010);
      chk($sformatf("stall%0d.uncached", k), dc.dc_uncached, 1);
      chk($sformatf("stall%0d.in_ready", k), up.in_ready, 0);
      step();
    end
    dc.dc_addr_ok = 1'b1;
    dc.dc_data_ok = 1'b1;
    dc.dc_rdata   = 32'h1234_5678;
    step();
    dc.dc_addr_ok = 1'b0;
    dc.dc_data_ok = 1'b0;
    chk("same_cycle.out_valid", up.out_valid, 1);
    chk("same_cycle.out_rdata", up.out_rdata, 32'h1234_5678);
    step();
    chk("same_cycle.pulse", up.out_valid, 0);

    // Flush in WAIT, data_ok two cycles later is discarded
    x = vecs[0];
    capture(x, 32'h0);
    dc.dc_addr_ok = 1'b1;
    step();
    dc.dc_addr_ok = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("drain.in_ready0", up.in_ready, 0);
    chk("drain.out_valid0", up.out_valid, 0);
    step();
    chk("drain.in_ready1", up.in_ready, 0);
    dc.dc_data_ok = 1'b1;
    dc.dc_rdata   = 32'h5555_AAAA;
    step();
    dc.dc_data_ok = 1'b0;
    chk("drain.out_valid", up.out_valid, 0);
    chk("drain.in_ready", up.in_ready, 1);

    // Flush in REQ before addr_ok aborts at once
    capture(x, 32'h0);
    chk("req_flush.dc_req_before", dc.dc_req, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("req_flush.dc_req", dc.dc_req, 0);
    chk("req_flush.out_valid", up.out_valid, 0);
    chk("req_flush.in_ready", up.in_ready, 1);

    // Flush together with addr_ok: accepted request must be drained
    capture(x, 32'h0);
    flush = 1'b1;
    dc.dc_addr_ok = 1'b1;
    step();
    flush = 1'b0;
    dc.dc_addr_ok = 1'b0;
    chk("acc_flush.in_ready", up.in_ready, 0);
    chk("acc_flush.dc_req", dc.dc_req, 0);
    dc.dc_data_ok = 1'b1;
    step();
    dc.dc_data_ok = 1'b0;
    chk("acc_flush.out_valid", up.out_valid, 0);
    chk("acc_flush.idle", up.in_ready, 1);

    // Flush coinciding with in_valid blocks the capture
    drive_req(x, 32'h0);
    up.in_valid = 1'b1;
    flush = 1'b1;
    step();
    up.in_valid = 1'b0;
    flush = 1'b0;
    chk("blocked.in_ready", up.in_ready, 1);
    chk("blocked.dc_req", dc.dc_req, 0);

    // Asynchronous reset while in WAIT
    capture(x, 32'h0);
    dc.dc_addr_ok = 1'b1;
    step();
    dc.dc_addr_ok = 1'b0;
    chk("wait.in_ready", up.in_ready, 0);
    #2 resetn = 1'b0;
    #1;
    chk("arst.in_ready", up.in_ready, 1);
    chk("arst.dc_req", dc.dc_req, 0);
    chk("arst.out_valid", up.out_valid, 0);
    chk("arst.dc_addr", dc.dc_addr, 0);
    @(negedge clk) resetn = 1'b1;
    step();
    chk("post_rst.in_ready", up.in_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
